io_output_streamer: RTL and testbench

//  Host-side end of the processor I/O output path: starts a program run by pulsing startIO.

---
 rtl/io_output_streamer.sv | 166 ++++++++++++++++
 tb/tb_io_output_streamer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/io_output_streamer.sv
// io_output_streamer: starts a processor run, captures its output words into a
// FIFO and streams them to the host LSB-byte first over valid/ready.
module io_output_streamer #(
    parameter int unsigned WIDTH  = 36,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned NBYTES = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     hostStart,
    input  logic                     hostStop,
    output logic                     startIO,
    input  logic                     outFlagIOE,
    input  logic [WIDTH-1:0]         procOut,
    output logic [7:0]               byteData,
    output logic                     byteValid,
    input  logic                     byteReady,
    output logic                     byteLast,
    output logic [$clog2(DEPTH):0]   fifoCount,
    output logic                     overflow,
    output logic                     busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = NBYTES * 8;
    localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {CTRL_IDLE, CTRL_START, CTRL_RUN} ctrlState_t;
    typedef enum logic       {SER_EMPTY, SER_SEND} serState_t;

    ctrlState_t         ctrlState;
    serState_t          serState;
    logic               hostStartPrev;
    logic [WIDTH-1:0]   fifoMem [DEPTH];
    logic [AW-1:0]      wrPtr;
    logic [AW-1:0]      rdPtr;
    logic [SW-1:0]      shiftReg;
    logic [IW-1:0]      byteIdx;

    logic fifoEmpty;
    logic fifoFull;
    logic handshake;
    logic pop;
    logic pushReq;
    logic push;
    logic drop;
    logic startEdge;

    // FIFO push/pop decisions; a pop frees a slot for a same-cycle push even when full
    always_comb begin
        fifoEmpty = (fifoCount == '0);
        fifoFull  = (fifoCount == CW'(DEPTH));
        handshake = byteValid && byteReady;
        pop       = !fifoEmpty && ((serState == SER_EMPTY) || (handshake && byteLast));
        pushReq   = (ctrlState == CTRL_RUN) && outFlagIOE;
        push      = pushReq && (!fifoFull || pop);
        drop      = pushReq && fifoFull && !pop;
        startEdge = hostStart && !hostStartPrev;
    end

    assign byteValid = (serState == SER_SEND);
    assign byteData  = shiftReg[7:0];
    assign busy      = (ctrlState == CTRL_RUN) || !fifoEmpty || (serState == SER_SEND);

    // Control FSM: start pulse, capture window, sticky overflow
    always_ff @(posedge clock) begin
        if (reset) begin
            ctrlState     <= CTRL_IDLE;
            hostStartPrev <= 1'b0;
            startIO       <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            hostStartPrev <= hostStart;
            startIO       <= 1'b0;
            case (ctrlState)
                CTRL_IDLE: begin
                    if (startEdge) begin
                        ctrlState <= CTRL_START;
                        startIO   <= 1'b1;
                        overflow  <= 1'b0;
                    end
                end
                CTRL_START: ctrlState <= CTRL_RUN;
                CTRL_RUN: begin
                    if (hostStop) begin
                        ctrlState <= CTRL_IDLE;
                    end
                end
                default: ctrlState <= CTRL_IDLE;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            if (push && !pop) begin
                fifoCount <= fifoCount + CW'(1);
            end else if (pop && !push) begin
                fifoCount <= fifoCount - CW'(1);
            end
        end
    end

    // FIFO storage, no reset needed: contents only read behind the count
    always_ff @(posedge clock) begin
        if (push) begin
            fifoMem[wrPtr] <= procOut;
        end
    end

    // Serializer FSM: loads a word and shifts it out one byte per handshake
    always_ff @(posedge clock) begin
        if (reset) begin
            serState <= SER_EMPTY;
            shiftReg <= '0;
            byteIdx  <= '0;
            byteLast <= 1'b0;
        end else begin
            case (serState)
                SER_EMPTY: begin
                    if (pop) begin
                        serState <= SER_SEND;
                        shiftReg <= SW'(fifoMem[rdPtr]);
                        byteIdx  <= '0;
                        byteLast <= (NBYTES == 1);
                    end
                end
                SER_SEND: begin
                    if (handshake) begin
                        if (byteLast) begin
                            if (pop) begin
                                shiftReg <= SW'(fifoMem[rdPtr]);
                                byteIdx  <= '0;
                                byteLast <= (NBYTES == 1);
                            end else begin
                                serState <= SER_EMPTY;
                                byteLast <= 1'b0;
                            end
                        end else begin
                            shiftReg <= shiftReg >> 8;
                            byteIdx  <= byteIdx + IW'(1);
                            byteLast <= ((byteIdx + IW'(1)) == IW'(NBYTES - 1));
                        end
                    end
                end
                default: serState <= SER_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_io_output_streamer.sv
// Directed bench for io_output_streamer with a byte scoreboard.
module tb_io_output_streamer;

    localparam int unsigned W  = 36;
    localparam int unsigned D  = 4;
    localparam int unsigned NB = 5;
    localparam int unsigned CW = $clog2(D) + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          hostStart = 1'b0;
    logic          hostStop = 1'b0;
    logic          startIO;
    logic          outFlagIOE = 1'b0;
    logic [W-1:0]  procOut = '0;
    logic [7:0]    byteData;
    logic          byteValid;
    logic          byteReady = 1'b0;
    logic          byteLast;
    logic [CW-1:0] fifoCount;
    logic          overflow;
    logic          busy;

    int passCount  = 0;
    int totalCount = 0;
    logic [8:0] expQ [$];

    io_output_streamer #(.WIDTH(W), .DEPTH(D), .NBYTES(NB)) dut (
        .clock(clock), .reset(reset), .hostStart(hostStart), .hostStop(hostStop),
        .startIO(startIO), .outFlagIOE(outFlagIOE), .procOut(procOut),
        .byteData(byteData), .byteValid(byteValid), .byteReady(byteReady),
        .byteLast(byteLast), .fifoCount(fifoCount), .overflow(overflow), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected bytes of a word, least-significant first, zero-extended top byte
    task automatic pushWord(input logic [W-1:0] w);
        logic [NB*8-1:0] ext;
        ext = {{(NB*8-W){1'b0}}, w};
        for (int i = 0; i < NB; i++) begin
            expQ.push_back({(i == NB - 1), ext[8*i +: 8]});
        end
    endtask

    task automatic capture(input logic [W-1:0] w, input bit keep);
        outFlagIOE = 1'b1;
        procOut    = w;
        if (keep) pushWord(w);
        tick();
        outFlagIOE = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drainTimeout", 64'(expQ.size()), 64'd0);
    endtask

    // Byte monitor: every valid byte must match the scoreboard head; popped on handshake
    always @(negedge clock) begin
        if (!reset && byteValid) begin
            if (expQ.size() == 0) begin
                check("spuriousByte", 64'(byteData), 64'hFFFF);
            end else begin
                check("byteData", 64'(byteData), 64'(expQ[0][7:0]));
                check("byteLast", 64'(byteLast), 64'(expQ[0][8]));
                if (byteReady) void'(expQ.pop_front());
            end
        end
    end

    initial begin
        int pulses;

        // reset state
        tick(); tick();
        check("rstStartIO", 64'(startIO), 64'd0);
        check("rstValid", 64'(byteValid), 64'd0);
        check("rstLast", 64'(byteLast), 64'd0);
        check("rstData", 64'(byteData), 64'd0);
        check("rstCount", 64'(fifoCount), 64'd0);
        check("rstOvf", 64'(overflow), 64'd0);
        check("rstBusy", 64'(busy), 64'd0);
        reset = 1'b0;
        tick();

        // start pulse: hostStart held for 3 cycles gives one startIO cycle
        hostStart = 1'b1;
        pulses = 0;
        tick(); check("startPulse1", 64'(startIO), 64'd1); pulses += int'(startIO);
        tick(); check("startPulse2", 64'(startIO), 64'd0); pulses += int'(startIO);
        tick(); check("startPulse3", 64'(startIO), 64'd0); pulses += int'(startIO);
        check("pulseCount", 64'(pulses), 64'd1);
        check("runBusy", 64'(busy), 64'd1);
        hostStart = 1'b0;

        // single word, byteReady high: valid two cycles after capture
        byteReady = 1'b1;
        capture(36'h9_8765_4321, 1'b1);
        check("latCount", 64'(fifoCount), 64'd1);
        check("latValid0", 64'(byteValid), 64'd0);
        tick();
        check("latValid1", 64'(byteValid), 64'd1);
        check("firstByte", 64'(byteData), 64'h21);
        drain(20);
        check("idleAfterWord", 64'(byteValid), 64'd0);

        // same word with byteReady toggling 1,0,0,1
        capture(36'h9_8765_4321, 1'b1);
        for (int c = 0; c < 40 && expQ.size() != 0; c++) begin
            byteReady = (c % 4 == 0) || (c % 4 == 3);
            tick();
        end
        check("stallDrain", 64'(expQ.size()), 64'd0);
        byteReady = 1'b1;
        tick(); tick();

        // fill: six back-to-back captures with the host stalled
        byteReady = 1'b0;
        for (int i = 1; i <= 6; i++) capture(W'(i), i != 6);
        check("fullCount", 64'(fifoCount), 64'd4);
        check("fullOvf", 64'(overflow), 64'd1);
        check("fullValid", 64'(byteValid), 64'd1);
        check("fullHead", 64'(byteData), 64'h01);
        byteReady = 1'b1;
        for (int i = 0; i < 25; i++) begin
            check("noBubble", 64'(byteValid), 64'd1);
            tick();
        end
        check("burstDone", 64'(byteValid), 64'd0);
        check("burstCount", 64'(fifoCount), 64'd0);
        check("burstQ", 64'(expQ.size()), 64'd0);

        // hostStop with a same-cycle word still captures; IDLE ignores words
        hostStop = 1'b1;
        capture(W'(13), 1'b1);
        hostStop = 1'b0;
        tick();
        capture(W'(14), 1'b0);
        drain(20);
        tick(); tick();
        check("idleBusy", 64'(busy), 64'd0);

        // restart clears overflow
        hostStart = 1'b1;
        tick();
        check("restartPulse", 64'(startIO), 64'd1);
        check("ovfCleared", 64'(overflow), 64'd0);
        tick();
        hostStart = 1'b0;

        // full FIFO, last-byte handshake coincides with a capture
        byteReady = 1'b0;
        for (int i = 7; i <= 11; i++) capture(W'(i), 1'b1);
        check("refillCount", 64'(fifoCount), 64'd4);
        byteReady = 1'b1;
        repeat (4) tick();
        check("atLastByte", 64'(byteLast), 64'd1);
        capture(W'(12), 1'b1);
        check("pushPopCount", 64'(fifoCount), 64'd4);
        check("pushPopOvf", 64'(overflow), 64'd0);
        check("pushPopValid", 64'(byteValid), 64'd1);
        check("pushPopHead", 64'(byteData), 64'h08);
        drain(40);
        tick(); tick();

        // reset in the middle of a word
        capture(36'hA_BCDE_F012, 1'b1);
        repeat (3) tick();
        reset = 1'b1;
        expQ.delete();
        tick();
        check("midRstValid", 64'(byteValid), 64'd0);
        check("midRstCount", 64'(fifoCount), 64'd0);
        check("midRstOvf", 64'(overflow), 64'd0);
        check("midRstBusy", 64'(busy), 64'd0);
        reset = 1'b0;
        repeat (10) tick();
        check("postRstValid", 64'(byteValid), 64'd0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
